// File: rtl/retrocomm_pkg.sv
// rtl/retrocomm_pkg.sv - shared types and constants for the RetroComm arbiter
// Purpose: FSM state enum, parameter defaults and the timeout response word.
// Ports: none (package).
package retrocomm_pkg;

  localparam int NREQ_DEFAULT    = 4;
  localparam int TIMEOUT_DEFAULT = 255;

  localparam logic [15:0] RETROCOMM_ERR_WORD = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/retrocomm_arbiter_if.sv
// rtl/retrocomm_arbiter_if.sv - requester, link and interrupt signals of the RetroComm arbiter
// Purpose: bundles every non-clock/reset signal of the arbiter.
// Ports (slave = arbiter view):
//   in : req, req_data, link_din, link_strobe, link_interrupt, irq_ack
//   out: grant, done, resp_data, timed_out, link_dout, link_raise, irq_pending
interface retrocomm_arbiter_if #(
  parameter int NREQ = retrocomm_pkg::NREQ_DEFAULT
);

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0][15:0]  req_data;
  logic [NREQ-1:0]        grant;
  logic [NREQ-1:0]        done;
  logic [15:0]            resp_data;
  logic                   timed_out;
  logic [15:0]            link_dout;
  logic                   link_raise;
  logic [15:0]            link_din;
  logic                   link_strobe;
  logic                   link_interrupt;
  logic                   irq_pending;
  logic                   irq_ack;

  modport slave (
    input  req, req_data, link_din, link_strobe, link_interrupt, irq_ack,
    output grant, done, resp_data, timed_out, link_dout, link_raise, irq_pending
  );

  modport master (
    output req, req_data, link_din, link_strobe, link_interrupt, irq_ack,
    input  grant, done, resp_data, timed_out, link_dout, link_raise, irq_pending
  );

endinterface

// File: rtl/retrocomm_arbiter_rr_arbiter.sv
// rtl/retrocomm_arbiter_rr_arbiter.sv - combinational round-robin requester selection
// Purpose: picks the first asserted request at or after ptr, wrapping around.
// Ports:
//   in : req   (NREQ request levels), ptr (PW-bit starting index)
//   out: grant (one-hot winner), valid (any request asserted)
module rr_arbiter
  import retrocomm_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic            valid
);

  logic [PW-1:0] idx;

  // Scan NREQ positions starting at ptr; the first hit wins and masks the rest.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PW'((int'(ptr) + i) % NREQ);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/retrocomm_arbiter.sv
// rtl/retrocomm_arbiter.sv - shares one RetroComm initiator link among NREQ requesters
// Purpose: round-robin arbitration, one command/response transaction at a time,
//          with response timeout and a latched target interrupt.
// Ports:
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : retrocomm_arbiter_if.slave (requester, link and interrupt signals)
module retrocomm_arbiter
  import retrocomm_pkg::*;
#(
  parameter int NREQ    = NREQ_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_n,
  retrocomm_arbiter_if.slave  bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] grant_r;
  logic [NREQ-1:0] done_r;
  logic [15:0]     resp_r;
  logic            timed_out_r;
  logic [15:0]     dout_r;
  logic            raise_r;
  logic            irq_prev;
  logic            irq_pending_r;

  logic [NREQ-1:0] rr_grant;
  logic            rr_valid;
  logic [PW-1:0]   rr_idx;
  logic [PW-1:0]   next_ptr;
  logic            irq_rise;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .req   (bus.req),
    .ptr   (ptr),
    .grant (rr_grant),
    .valid (rr_valid)
  );

  // One-hot winner to binary index, needed for the data mux and pointer update.
  always_comb begin
    rr_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rr_grant[i]) rr_idx = PW'(i);
    end
  end

  assign next_ptr = (owner == LAST_IDX) ? '0 : owner + PW'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      owner       <= '0;
      cnt         <= '0;
      grant_r     <= '0;
      done_r      <= '0;
      resp_r      <= '0;
      timed_out_r <= 1'b0;
      dout_r      <= '0;
      raise_r     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rr_valid) begin
            owner   <= rr_idx;
            grant_r <= rr_grant;
            dout_r  <= bus.req_data[rr_idx];
            raise_r <= 1'b1;
            state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          raise_r <= 1'b0;
          cnt     <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          // The strobe is tested first so a reply on the last allowed cycle still counts.
          if (bus.link_strobe) begin
            resp_r      <= bus.link_din;
            timed_out_r <= 1'b0;
            done_r      <= grant_r;
            state       <= ST_RESP;
          end else if (cnt == CNT_MAX) begin
            resp_r      <= RETROCOMM_ERR_WORD;
            timed_out_r <= 1'b1;
            done_r      <= grant_r;
            state       <= ST_RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RESP: begin
          done_r  <= '0;
          grant_r <= '0;
          ptr     <= next_ptr;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign irq_rise = bus.link_interrupt && !irq_prev;

  // A fresh rising edge takes priority over an acknowledge in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_prev      <= 1'b0;
      irq_pending_r <= 1'b0;
    end else begin
      irq_prev <= bus.link_interrupt;
      if (irq_rise) begin
        irq_pending_r <= 1'b1;
      end else if (bus.irq_ack) begin
        irq_pending_r <= 1'b0;
      end
    end
  end

  assign bus.grant       = grant_r;
  assign bus.done        = done_r;
  assign bus.resp_data   = resp_r;
  assign bus.timed_out   = timed_out_r;
  assign bus.link_dout   = dout_r;
  assign bus.link_raise  = raise_r;
  assign bus.irq_pending = irq_pending_r;

endmodule

// File: doc/retrocomm_arbiter.md
RETROCOMM_ARBITER -- requirements
Module: retrocomm_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one RetroComm initiator link.
REQ-002 Parameter TIMEOUT, default 255: maximum WAIT cycles before a transaction aborts.
REQ-003 Clk  input  1  single clock; every register updates on its rising edge.
REQ-004 Reset_n  input  1  reset, synchronous and active-low.
REQ-005 Req  input  NREQ  per-requester request level.
REQ-006 ReqData  input  NREQ x 16  per-requester command word.
REQ-007 Grant  output  NREQ  one-hot; identifies the owner of the current transaction.
REQ-008 Done  output  NREQ  one-cycle pulse to the owner; RespData and TimedOut are valid in that cycle.
REQ-009 RespData  output  16  response word.
REQ-010 TimedOut  output  1  qualifies Done; high means the response timed out.
REQ-011 LinkDout  output  16  command word driven to the target (initiator Dout).
REQ-012 LinkRaise  output  1  one-cycle strobe marking LinkDout valid.
REQ-013 LinkDin  input  16  target response word.
REQ-014 LinkStrobe  input  1  one-cycle target strobe marking LinkDin valid.
REQ-015 LinkInterrupt  input  1  target interrupt level.
REQ-016 IrqPending  output  1  latched interrupt indication.
REQ-017 IrqAck  input  1  clears IrqPending.

Function
REQ-018 The FSM SHALL have the states IDLE, SEND, WAIT and RESP.
REQ-019 IDLE: when any Req bit is set, select the first asserted index in round-robin order starting at pointer, latch that index and its ReqData into LinkDout, and go to SEND; when no Req bit is set, remain in IDLE.
REQ-020 SEND: LinkRaise=1 for exactly this cycle, timeout counter cleared, next state WAIT.
REQ-021 WAIT, LinkStrobe=1: capture LinkDin into RespData, TimedOut=0, next state RESP.
REQ-022 WAIT, LinkStrobe=0 and counter==TIMEOUT: RespData=16'hFFFF, TimedOut=1, next state RESP.
REQ-023 WAIT, any other case: increment the counter and remain in WAIT.
REQ-024 LinkStrobe and counter==TIMEOUT in the same cycle: the strobe wins, and the transaction completes normally.
REQ-025 RESP: Done[idx]=1 for this cycle only, pointer=(idx+1) mod NREQ, next state IDLE.
REQ-026 Grant[idx] SHALL be high in SEND, WAIT and RESP, and low in IDLE.
REQ-027 Latency: Req seen in IDLE at cycle 0 gives LinkRaise at cycle 1; LinkStrobe at cycle k gives Done at cycle k+1.
REQ-028 LinkStrobe SHALL be ignored in IDLE, SEND and RESP.
REQ-029 A Req drop during a transaction SHALL NOT abort it; Done is still issued.
REQ-030 Req held through Done SHALL be treated as a new request, subject to round-robin order.
REQ-031 Changes to ReqData after the IDLE latch SHALL NOT affect LinkDout.
REQ-032 The TIMEOUT compare SHALL use a counter of width clog2(TIMEOUT+1), which never wraps.
REQ-033 IrqPending SHALL set on a rising edge of LinkInterrupt, detected against a registered previous value.
REQ-034 IrqPending SHALL clear on IrqAck; when set and clear coincide, set wins.

Reset
REQ-035 While Reset_n=0 at a clock edge: state=IDLE, pointer=0, counter=0, edge register=0.
REQ-036 While Reset_n=0 at a clock edge, these outputs SHALL be 0: Grant, Done, RespData, TimedOut, LinkDout, LinkRaise, IrqPending.
REQ-037 Reset asserted mid-transaction SHALL abandon the transaction with no Done pulse; a late LinkStrobe after reset SHALL be ignored.

Structure
REQ-038 Package retrocomm_pkg SHALL hold the FSM state enum, the NREQ and TIMEOUT defaults, and the constant RETROCOMM_ERR_WORD=16'hFFFF.
REQ-039 Round-robin selection SHALL be a sub-module named rr_arbiter.
REQ-040 rr_arbiter SHALL be combinational, with inputs Req and pointer and outputs a one-hot grant and a valid flag.

Verification
REQ-041 Single request: after reset, Req=0001, ReqData=16'h1234, LinkStrobe at cycle 4 with LinkDin=16'hBEEF -> LinkRaise at cycle 1 with LinkDout=16'h1234; Done=0001 at cycle 5 with RespData=16'hBEEF, TimedOut=0.
REQ-042 Fairness: Req=1111 held continuously, target replies 2 cycles after each Raise -> Grant sequence 0001, 0010, 0100, 1000, 0001.
REQ-043 Timeout: Req=0100, no LinkStrobe -> Done=0100 exactly TIMEOUT+1 cycles after WAIT entry; RespData=16'hFFFF, TimedOut=1.
REQ-044 Boundary: LinkStrobe coincident with counter==TIMEOUT -> TimedOut=0 and RespData=LinkDin; a stray LinkStrobe in IDLE -> no Done, state unchanged.
REQ-045 Reset in WAIT: Reset_n=0 for one cycle -> next cycle all outputs 0; a subsequent LinkStrobe produces no Done.
REQ-046 Interrupt: LinkInterrupt 0->1 -> IrqPending=1 the next cycle; IrqAck during a fresh rising edge -> IrqPending remains 1.
